// File: rtl/key_debounce_filter_pkg.sv
// Shared state encodings and default timing constants for the push-button front end.
package key_debounce_filter_pkg;

  localparam int KEY_STATE_WIDTH = 3;

  typedef enum logic [KEY_STATE_WIDTH-1:0] {
    KEY_IDLE      = 3'd0,
    KEY_PRESS_CHK = 3'd1,
    KEY_PRESSED   = 3'd2,
    KEY_LONG      = 3'd3,
    KEY_REL_CHK   = 3'd4
  } key_state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 2_000_000;
  localparam int DEF_LONG_PRESS_CYCLES = 300_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; latency 2 clk edges.
// RST_VAL sets the level both flops take on reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_filter.sv
// Button conditioner: sync + stability filter, press/release/long-press pulses.
// Press/release pulses land DEBOUNCE_CYCLES+2 edges after a steady input change.
module key_debounce_filter
  import key_debounce_filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter bit BTN_ACTIVE_HIGH   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic key_press_pulse,
  output logic key_release_pulse,
  output logic key_long_pulse,
  output logic key_long_held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic key_pin;
  logic key_s;

  // Polarity is corrected before the synchronizer so its reset level is always "released".
  assign key_pin = BTN_ACTIVE_HIGH ? key_raw : ~key_raw;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_pin),
    .q   (key_s)
  );

  key_state_e    state, state_nxt;
  logic [DW-1:0] deb_cnt, deb_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          long_fired, long_fired_nxt;
  logic          level_nxt, press_nxt, release_nxt, long_nxt, held_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= KEY_IDLE;
      deb_cnt           <= '0;
      hold_cnt          <= '0;
      long_fired        <= 1'b0;
      key_level         <= 1'b0;
      key_press_pulse   <= 1'b0;
      key_release_pulse <= 1'b0;
      key_long_pulse    <= 1'b0;
      key_long_held     <= 1'b0;
    end else begin
      state             <= state_nxt;
      deb_cnt           <= deb_nxt;
      hold_cnt          <= hold_nxt;
      long_fired        <= long_fired_nxt;
      key_level         <= level_nxt;
      key_press_pulse   <= press_nxt;
      key_release_pulse <= release_nxt;
      key_long_pulse    <= long_nxt;
      key_long_held     <= held_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    deb_nxt        = deb_cnt;
    hold_nxt       = hold_cnt;
    long_fired_nxt = long_fired;
    level_nxt      = key_level;
    held_nxt       = key_long_held;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_nxt       = 1'b0;

    case (state)
      KEY_IDLE: begin
        level_nxt = 1'b0;
        if (key_s) begin
          state_nxt = KEY_PRESS_CHK;
          deb_nxt   = DW'(1);
        end else begin
          deb_nxt   = '0;
        end
      end

      KEY_PRESS_CHK: begin
        if (!key_s) begin
          state_nxt = KEY_IDLE;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = KEY_PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
          hold_nxt  = '0;
          deb_nxt   = '0;
        end else begin
          deb_nxt   = deb_cnt + DW'(1);
        end
      end

      KEY_PRESSED: begin
        // Saturates at the terminal count so a paused hold can resume without wrapping.
        if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + HW'(1);
        if (!key_s) begin
          state_nxt      = KEY_REL_CHK;
          deb_nxt        = DW'(1);
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt      = KEY_LONG;
          long_nxt       = 1'b1;
          held_nxt       = 1'b1;
          long_fired_nxt = 1'b1;
        end
      end

      KEY_LONG: begin
        if (!key_s) begin
          state_nxt = KEY_REL_CHK;
          deb_nxt   = DW'(1);
        end
      end

      KEY_REL_CHK: begin
        if (key_s) begin
          state_nxt = long_fired ? KEY_LONG : KEY_PRESSED;
          deb_nxt   = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt      = KEY_IDLE;
          level_nxt      = 1'b0;
          held_nxt       = 1'b0;
          long_fired_nxt = 1'b0;
          release_nxt    = 1'b1;
          deb_nxt        = '0;
        end else begin
          deb_nxt        = deb_cnt + DW'(1);
        end
      end

      default: begin
        state_nxt = KEY_IDLE;
        deb_nxt   = '0;
        level_nxt = 1'b0;
        held_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce_filter.sv
// Randomized + directed bench for key_debounce_filter against a run-length reference model.
module tb_key_debounce_filter;

  localparam int D = 8;
  localparam int L = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_raw = 1'b0;
  logic key_raw_n;

  logic lvl_a, pp_a, rp_a, lp_a, held_a;
  logic lvl_b, pp_b, rp_b, lp_b, held_b;

  assign key_raw_n = ~key_raw;

  always #5 clk = ~clk;

  key_debounce_filter #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .BTN_ACTIVE_HIGH(1'b1)) dut (
    .clk (clk), .rst (rst), .key_raw (key_raw),
    .key_level (lvl_a), .key_press_pulse (pp_a), .key_release_pulse (rp_a),
    .key_long_pulse (lp_a), .key_long_held (held_a)
  );

  key_debounce_filter #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .BTN_ACTIVE_HIGH(1'b0)) dut_n (
    .clk (clk), .rst (rst), .key_raw (key_raw_n),
    .key_level (lvl_b), .key_press_pulse (pp_b), .key_release_pulse (rp_b),
    .key_long_pulse (lp_b), .key_long_held (held_b)
  );

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  // Reference model: accepted level plus length of the current run disagreeing with it.
  logic s1 = 0, s2 = 0, ks;
  logic m_lvl = 0, m_pp = 0, m_rp = 0, m_lp = 0, m_long = 0;
  int   run = 0, hold = 0;

  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      s1 = 0; s2 = 0; m_lvl = 0; m_pp = 0; m_rp = 0; m_lp = 0; m_long = 0;
      run = 0; hold = 0;
    end else begin
      ks = s2; s2 = s1; s1 = key_raw;
      m_pp = 0; m_rp = 0; m_lp = 0;
      if (!m_lvl) begin
        if (ks) begin
          run++;
          if (run == D) begin m_lvl = 1; m_pp = 1; run = 0; hold = 0; end
        end else run = 0;
      end else if (!ks) begin
        if (run == 0 && !m_long && hold < L - 1) hold++;
        run++;
        if (run == D) begin m_lvl = 0; m_rp = 1; m_long = 0; run = 0; end
      end else begin
        if (run == 0 && !m_long) begin
          if (hold == L - 1) begin m_lp = 1; m_long = 1; end
          else hold++;
        end
        run = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%b expected=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  int last_press = -1, last_press_n = -1, last_rel = -1, last_long = -1;
  int press_tot = 0, rel_tot = 0, long_tot = 0;

  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      chk("level",      lvl_a,  m_lvl);
      chk("press",      pp_a,   m_pp);
      chk("release",    rp_a,   m_rp);
      chk("long",       lp_a,   m_lp);
      chk("held",       held_a, m_long);
      chk("level_n",    lvl_b,  m_lvl);
      chk("press_n",    pp_b,   m_pp);
      chk("release_n",  rp_b,   m_rp);
      chk("long_n",     lp_b,   m_lp);
      chk("held_n",     held_b, m_long);
      if (pp_a === 1'b1) begin last_press = edge_cnt; press_tot++; end
      if (pp_b === 1'b1) last_press_n = edge_cnt;
      if (rp_a === 1'b1) begin last_rel = edge_cnt; rel_tot++; end
      if (lp_a === 1'b1) begin last_long = edge_cnt; long_tot++; end
    end
  end

  task automatic drive(input logic k, input int n);
    key_raw = k;
    repeat (n) @(negedge clk);
  endtask

  int fe, p0, r0, l0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_level", lvl_a, 1'b0);
    chk("rst_held",  held_a, 1'b0);
    drive(0, 5);

    // Clean press: pulse on the 10th sampling edge, both polarities.
    p0 = press_tot; l0 = long_tot;
    fe = edge_cnt + 1;
    drive(1, 20);
    #1;
    chk_int("clean_press_edge",   last_press,   fe + 9);
    chk_int("clean_press_edge_n", last_press_n, fe + 9);
    chk_int("clean_press_count",  press_tot - p0, 1);
    chk_int("clean_no_long",      long_tot - l0, 0);
    chk("clean_level", lvl_a, 1'b1);
    drive(0, 20);

    // Bounce reject: highs of 3, 5, 7 separated by short lows.
    p0 = press_tot;
    drive(1, 3); drive(0, 2); drive(1, 5); drive(0, 2); drive(1, 7); drive(0, 2);
    #1;
    chk_int("bounce_no_press", press_tot - p0, 0);
    fe = edge_cnt + 1;
    drive(1, 20);
    #1;
    chk_int("bounce_press_edge", last_press, fe + 9);
    chk_int("bounce_press_count", press_tot - p0, 1);
    drive(0, 20);

    // Long press, then release through a bounce.
    l0 = long_tot; r0 = rel_tot;
    fe = edge_cnt + 1;
    drive(1, 60);
    #1;
    chk_int("long_press_edge", last_press, fe + 9);
    chk_int("long_edge",       last_long,  fe + 41);
    chk_int("long_count",      long_tot - l0, 1);
    chk("long_held", held_a, 1'b1);
    drive(0, 4); drive(1, 2);
    #1;
    chk_int("rel_bounce_no_release", rel_tot - r0, 0);
    fe = edge_cnt + 1;
    drive(0, 20);
    #1;
    chk_int("release_edge", last_rel, fe + 9);
    chk("release_held_clear", held_a, 1'b0);
    chk_int("release_count", rel_tot - r0, 1);

    // Reset while PRESSED: outputs clear, no release pulse, next press is clean.
    drive(1, 15);
    r0 = rel_tot;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_level", lvl_a, 1'b0);
    chk("rst_mid_level_n", lvl_b, 1'b0);
    drive(0, 20);
    #1;
    chk_int("rst_mid_no_release", rel_tot - r0, 0);
    fe = edge_cnt + 1;
    drive(1, 20);
    #1;
    chk_int("post_rst_press_edge", last_press, fe + 9);
    drive(0, 20);

    // Random bursts, some long enough to accept or long-press, with rare resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) drive(1'($urandom_range(0, 1)), $urandom_range(30, 80));
      else                           drive(1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    drive(0, 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_debounce_filter.md
Name: key_debounce_filter

Overview:
- Front-end conditioning stage for every hood push-button.
- Takes the raw, asynchronous, bouncing button pin and applies a 2-flop synchronizer and a counter-based stability filter.
- Produces a debounced level plus single-cycle press, release and long-press pulses.
- key_level drives the toggle_signal input of the stand-mode controllers; key_long_pulse feeds the power/long-press logic.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable synchronized cycles required to accept a change (20 ms at 100 MHz); legal range ≥2.
- LONG_PRESS_CYCLES, 300_000_000, cycles spent in PRESSED before the long-press pulse fires (3 s at 100 MHz); legal range > DEBOUNCE_CYCLES.
- BTN_ACTIVE_HIGH, 1, raw pin polarity; 0 inverts key_raw before synchronization.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous, active-high reset
- key_raw  input  1  raw button pin, asynchronous to clk
- key_level  output  1  debounced pressed level, registered
- key_press_pulse  output  1  one-cycle pulse on accepted press
- key_release_pulse  output  1  one-cycle pulse on accepted release
- key_long_pulse  output  1  one-cycle pulse when hold reaches LONG_PRESS_CYCLES
- key_long_held  output  1  high from long pulse until accepted release

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - All outputs 0.
  - FSM in IDLE, all counters 0, long_fired 0.
  - Both synchronizer flops loaded with the inactive level.
- Synchronizer: key_raw, polarity-corrected, passes through 2 flops to give key_s. The FSM sees only key_s.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_CYCLES) bits wide.
  - hold_cnt is $clog2(LONG_PRESS_CYCLES) bits wide.
  - Both saturate; neither ever wraps.
- States and transitions:
  - IDLE: key_level=0. If key_s=1, go to PRESS_CHK with deb_cnt=1.
  - PRESS_CHK:
    - key_s=0: return to IDLE, deb_cnt=0; no pulse (bounce rejected).
    - key_s=1 and deb_cnt=DEBOUNCE_CYCLES-1: go to PRESSED, set key_level=1, pulse key_press_pulse, hold_cnt=0.
    - Otherwise deb_cnt+1.
  - PRESSED:
    - hold_cnt+1 each cycle.
    - If hold_cnt=LONG_PRESS_CYCLES-1: go to LONG, pulse key_long_pulse, set key_long_held=1, long_fired=1.
    - If key_s=0: go to REL_CHK with deb_cnt=1. This takes priority over the long-press transition in the same cycle.
  - LONG: key_level=1 and key_long_held=1; hold_cnt frozen. If key_s=0, go to REL_CHK with deb_cnt=1.
  - REL_CHK:
    - key_level stays 1; hold_cnt paused.
    - key_s=1: return to LONG if long_fired, else PRESSED. No pulse.
    - key_s=0 and deb_cnt=DEBOUNCE_CYCLES-1: go to IDLE, clear key_level, key_long_held and long_fired, pulse key_release_pulse.
- Latency:
  - With key_raw steady, key_press_pulse asserts exactly DEBOUNCE_CYCLES+2 rising edges after the first edge that samples key_raw active. The 2 extra edges are the synchronizer.
  - key_release_pulse follows the same rule for the inactive level.
- Pulses:
  - Each pulse is high for exactly 1 cycle; pulses are mutually exclusive.
  - key_press_pulse and key_level rise on the same edge; key_release_pulse and key_level fall on the same edge.
  - key_long_pulse fires at most once per press.
- Glitch shorter than DEBOUNCE_CYCLES: produces no output change in either direction.
- Reset mid-operation: rst in any state forces the reset values on the next edge. No release pulse is emitted.

Decomposition:
- parameters.vh (shared header):
  - KEY_IDLE / KEY_PRESS_CHK / KEY_PRESSED / KEY_LONG / KEY_REL_CHK state encodings, 3-bit.
  - KEY_STATE_WIDTH.
  - Default DEBOUNCE_CYCLES and LONG_PRESS_CYCLES values.
- One sub-module, sync_2ff: 2-flop synchronizer with a reset-value parameter. It is reused by other raw-input blocks.

Test Plan:
- Clean press: DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32; key_raw 0→1 held 20 cycles -> key_press_pulse high exactly 1 cycle at edge 10; key_level=1 from edge 10; no long pulse.
- Bounce reject: key_raw toggles 1,0 with high periods of 3, 5 and 7 cycles, then holds 1 -> no pulse during bouncing; single press pulse 10 edges after the final rise.
- Long press: hold key_raw=1 for 60 cycles -> press pulse at edge 10; key_long_pulse 1 cycle at edge 42; key_long_held=1 until release.
- Release with bounce: from LONG, key_raw low 4 cycles, high 2, then low -> key_level stays 1 through the bounce; release pulse at 10 edges after the final fall; key_long_held cleared on the same edge.
- Reset mid-press: assert rst for 1 cycle while in PRESSED -> all outputs 0 on the next edge; no release pulse; next clean press behaves as in scenario 1.
- Polarity: BTN_ACTIVE_HIGH=0; key_raw idle 1, pulled to 0 for 20 cycles -> identical pulses and timing to scenario 1.
